// File: rtl/ddr3_traffic_gen_if.sv
// MIG 7-series app_* user-interface bundle: command, write-data and read-data channels.
// The traffic generator is the master; the MIG (or a bench model of it) is the slave.
interface ddr3_traffic_gen_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 512
);
  logic [ADDR_W-1:0]   app_addr;
  logic [2:0]          app_cmd;
  logic                app_en;
  logic                app_rdy;
  logic [DATA_W-1:0]   app_wdf_data;
  logic                app_wdf_wren;
  logic                app_wdf_end;
  logic [DATA_W/8-1:0] app_wdf_mask;
  logic                app_wdf_rdy;
  logic [DATA_W-1:0]   app_rd_data;
  logic                app_rd_data_valid;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );
endinterface

// File: rtl/ddr3_traffic_gen.sv
// Write-then-read-verify traffic generator for the MIG app_* interface.
// Writes a pattern, idles for a gap, reads it back and checks every returned beat in order.
module ddr3_traffic_gen #(
  parameter int ADDR_W        = 30,
  parameter int DATA_W        = 512,
  parameter int ADDR_STEP     = 8,
  parameter int CNT_W         = 16,
  parameter int GAP_CYCLES    = 500,
  parameter int DRAIN_TIMEOUT = 4096
) (
  input  logic                 ui_clk,
  input  logic                 reset,
  ddr3_traffic_gen_if.master   app,
  input  logic                 i_init_calib_complete,
  input  logic                 i_start,
  input  logic [1:0]           i_mode,
  input  logic [31:0]          i_seed,
  input  logic [ADDR_W-1:0]    i_base_addr,
  input  logic [CNT_W-1:0]     i_word_count,
  input  logic                 i_loop_en,
  input  logic                 i_stop,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
  output logic                 o_timeout,
  output logic [CNT_W-1:0]     o_err_count,
  output logic [DATA_W/64-1:0] o_err_lanes,
  output logic [ADDR_W-1:0]    o_first_err_addr,
  output logic [CNT_W-1:0]     o_pass_count
);
  localparam int LANES32 = DATA_W / 32;
  localparam int LANES64 = DATA_W / 64;

  typedef enum logic [2:0] {S_IDLE, S_WAIT_CAL, S_WRITE, S_GAP, S_READ, S_DRAIN, S_DONE} state_t;

  function automatic logic [DATA_W-1:0] patternOf(input logic [CNT_W-1:0] idx,
                                                  input logic [1:0] md, input logic [31:0] sd);
    logic [31:0] idx32;
    logic [31:0] lane;
    patternOf = '0;
    idx32 = 32'(idx);
    for (int k = 0; k < LANES32; k++) begin
      case (md)
        2'd0:    lane = idx32;
        2'd1:    lane = 32'd1 << 5'(idx32 + 32'(k));
        2'd2:    lane = (idx32 * 32'h9E37_79B1) ^ sd ^ 32'(k);
        default: lane = ~idx32;
      endcase
      patternOf[32*k +: 32] = lane;
    end
  endfunction

  function automatic logic [ADDR_W-1:0] addrOf(input logic [ADDR_W-1:0] base,
                                               input logic [CNT_W-1:0] idx);
    return base + ADDR_W'(ADDR_STEP) * ADDR_W'(idx);
  endfunction

  state_t              r_state;
  logic [1:0]          r_mode;
  logic [31:0]         r_seed;
  logic [ADDR_W-1:0]   r_base;
  logic [CNT_W-1:0]    r_count, r_wi, r_ri, r_ci;
  logic                r_cmdDone, r_datDone, r_stopSeen, r_firstSeen;
  logic [31:0]         r_gapCnt, r_drainCnt;
  logic [DATA_W-1:0]   r_expData, r_appData;
  logic [ADDR_W-1:0]   r_appAddr;
  logic [2:0]          r_appCmd;
  logic                r_appEn, r_appWren;
  logic                r_busy, r_done, r_timeout;
  logic [CNT_W-1:0]    r_errCount, r_passCount;
  logic [LANES64-1:0]  r_errLanes;
  logic [ADDR_W-1:0]   r_firstErrAddr;

  logic                w_cmdDone, w_datDone, w_checking, w_stopSeen;
  logic [CNT_W-1:0]    w_wiNext, w_riNext, w_ciNext;
  logic [LANES64-1:0]  w_laneDiff;

  // Each write side is done once accepted now or in an earlier cycle of the same word.
  assign w_cmdDone  = r_cmdDone | (r_appEn & app.app_rdy);
  assign w_datDone  = r_datDone | (r_appWren & app.app_wdf_rdy);
  assign w_wiNext   = r_wi + 1'b1;
  assign w_riNext   = r_ri + 1'b1;
  assign w_ciNext   = r_ci + 1'b1;
  assign w_stopSeen = r_stopSeen | i_stop;
  assign w_checking = ((r_state == S_READ) || (r_state == S_DRAIN)) &&
                      app.app_rd_data_valid && (r_ci != r_count);

  always_comb begin
    w_laneDiff = '0;
    for (int j = 0; j < LANES64; j++)
      w_laneDiff[j] = |(app.app_rd_data[64*j +: 64] ^ r_expData[64*j +: 64]);
  end

  assign app.app_addr     = r_appAddr;
  assign app.app_cmd      = r_appCmd;
  assign app.app_en       = r_appEn;
  assign app.app_wdf_data = r_appData;
  assign app.app_wdf_wren = r_appWren;
  assign app.app_wdf_end  = r_appWren;
  assign app.app_wdf_mask = '0;

  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_pass           = r_done & (r_errCount == '0) & ~r_timeout;
  assign o_timeout        = r_timeout;
  assign o_err_count      = r_errCount;
  assign o_err_lanes      = r_errLanes;
  assign o_first_err_addr = r_firstErrAddr;
  assign o_pass_count     = r_passCount;

  always_ff @(posedge ui_clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_mode         <= '0;
      r_seed         <= '0;
      r_base         <= '0;
      r_count        <= '0;
      r_wi           <= '0;
      r_ri           <= '0;
      r_ci           <= '0;
      r_cmdDone      <= 1'b0;
      r_datDone      <= 1'b0;
      r_stopSeen     <= 1'b0;
      r_firstSeen    <= 1'b0;
      r_gapCnt       <= '0;
      r_drainCnt     <= '0;
      r_expData      <= '0;
      r_appData      <= '0;
      r_appAddr      <= '0;
      r_appCmd       <= '0;
      r_appEn        <= 1'b0;
      r_appWren      <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_timeout      <= 1'b0;
      r_errCount     <= '0;
      r_passCount    <= '0;
      r_errLanes     <= '0;
      r_firstErrAddr <= '0;
    end else begin
      // r_expData always holds the pattern for r_ci so the compare is a plain XOR.
      if (w_checking) begin
        r_ci      <= w_ciNext;
        r_expData <= patternOf(w_ciNext, r_mode, r_seed);
        if (|w_laneDiff) begin
          if (r_errCount != {CNT_W{1'b1}})
            r_errCount <= r_errCount + 1'b1;
          r_errLanes <= r_errLanes | w_laneDiff;
          if (!r_firstSeen) begin
            r_firstSeen    <= 1'b1;
            r_firstErrAddr <= addrOf(r_base, r_ci);
          end
        end
      end
      if (r_state inside {S_WAIT_CAL, S_WRITE, S_GAP, S_READ, S_DRAIN})
        r_stopSeen <= w_stopSeen;

      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_mode      <= i_mode;
            r_seed      <= i_seed;
            r_base      <= i_base_addr;
            r_count     <= i_word_count;
            r_errCount  <= '0;
            r_errLanes  <= '0;
            r_firstSeen <= 1'b0;
            r_firstErrAddr <= '0;
            r_passCount <= '0;
            r_timeout   <= 1'b0;
            r_stopSeen  <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_state     <= S_WAIT_CAL;
          end
        end
        S_WAIT_CAL: begin
          if (r_count == '0) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (i_init_calib_complete) begin
            r_wi      <= '0;
            r_ci      <= '0;
            r_cmdDone <= 1'b0;
            r_datDone <= 1'b0;
            r_appEn   <= 1'b1;
            r_appWren <= 1'b1;
            r_appCmd  <= 3'b000;
            r_appAddr <= addrOf(r_base, '0);
            r_appData <= patternOf('0, r_mode, r_seed);
            r_state   <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (w_cmdDone && w_datDone) begin
            r_cmdDone <= 1'b0;
            r_datDone <= 1'b0;
            if (w_wiNext == r_count) begin
              r_appEn   <= 1'b0;
              r_appWren <= 1'b0;
              r_gapCnt  <= '0;
              r_state   <= S_GAP;
            end else begin
              r_wi      <= w_wiNext;
              r_appAddr <= addrOf(r_base, w_wiNext);
              r_appData <= patternOf(w_wiNext, r_mode, r_seed);
              r_appEn   <= 1'b1;
              r_appWren <= 1'b1;
            end
          end else begin
            r_cmdDone <= w_cmdDone;
            r_datDone <= w_datDone;
            r_appEn   <= ~w_cmdDone;
            r_appWren <= ~w_datDone;
          end
        end
        S_GAP: begin
          if (r_gapCnt == 32'(GAP_CYCLES - 1)) begin
            r_ri      <= '0;
            r_ci      <= '0;
            r_expData <= patternOf('0, r_mode, r_seed);
            r_appCmd  <= 3'b001;
            r_appAddr <= addrOf(r_base, '0);
            r_appEn   <= 1'b1;
            r_state   <= S_READ;
          end else begin
            r_gapCnt <= r_gapCnt + 1;
          end
        end
        S_READ: begin
          if (r_appEn && app.app_rdy) begin
            if (w_riNext == r_count) begin
              r_appEn    <= 1'b0;
              r_drainCnt <= '0;
              r_state    <= S_DRAIN;
            end else begin
              r_ri      <= w_riNext;
              r_appAddr <= addrOf(r_base, w_riNext);
            end
          end
        end
        S_DRAIN: begin
          if (r_ci == r_count) begin
            r_passCount <= r_passCount + 1'b1;
            if (i_loop_en && !w_stopSeen) begin
              r_wi       <= '0;
              r_ci       <= '0;
              r_cmdDone  <= 1'b0;
              r_datDone  <= 1'b0;
              r_stopSeen <= 1'b0;
              r_appEn    <= 1'b1;
              r_appWren  <= 1'b1;
              r_appCmd   <= 3'b000;
              r_appAddr  <= addrOf(r_base, '0);
              r_appData  <= patternOf('0, r_mode, r_seed);
              r_state    <= S_WRITE;
            end else begin
              r_appCmd <= 3'b000;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
          end else if (r_drainCnt == 32'(DRAIN_TIMEOUT - 1)) begin
            r_timeout <= 1'b1;
            r_appCmd  <= 3'b000;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_drainCnt <= r_drainCnt + 1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ddr3_traffic_gen.sv
// Directed bench for ddr3_traffic_gen: a small MIG model with stalls, corruption and beat dropping.
// Expected values come from the pattern/address rules and hand-computed constants.
module tb_ddr3_traffic_gen;
  localparam int ADDR_W = 30;
  localparam int DATA_W = 512;
  localparam int CNT_W  = 16;

  logic ui_clk = 1'b0;
  logic reset  = 1'b1;
  always #5 ui_clk = ~ui_clk;

  logic                 calDone = 1'b1;
  logic                 start   = 1'b0;
  logic [1:0]           mode    = '0;
  logic [31:0]          seed    = '0;
  logic [ADDR_W-1:0]    baseAddr = '0;
  logic [CNT_W-1:0]     wordCount = '0;
  logic                 loopEn  = 1'b0;
  logic                 stop    = 1'b0;
  logic                 busy, done, passOut, timedOut;
  logic [CNT_W-1:0]     errCount, passCount;
  logic [DATA_W/64-1:0] errLanes;
  logic [ADDR_W-1:0]    firstErrAddr;

  ddr3_traffic_gen_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mig ();

  ddr3_traffic_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ADDR_STEP(8), .CNT_W(CNT_W),
                     .GAP_CYCLES(500), .DRAIN_TIMEOUT(4096)) dut (
    .ui_clk(ui_clk), .reset(reset), .app(mig),
    .i_init_calib_complete(calDone), .i_start(start), .i_mode(mode), .i_seed(seed),
    .i_base_addr(baseAddr), .i_word_count(wordCount), .i_loop_en(loopEn), .i_stop(stop),
    .o_busy(busy), .o_done(done), .o_pass(passOut), .o_timeout(timedOut),
    .o_err_count(errCount), .o_err_lanes(errLanes), .o_first_err_addr(firstErrAddr),
    .o_pass_count(passCount)
  );

  int checkCount = 0;
  int failCount  = 0;

  // Model knobs, written only by the stimulus process
  logic clearReq   = 1'b1;
  logic stallEn    = 1'b0;
  logic dropLast   = 1'b0;
  int   dropIdx    = 0;
  int   corruptIdx = -1;
  int   corruptBit = 0;

  // Model state, written only by the model process
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
  logic [ADDR_W-1:0] wrAddrQ[$], rdAddrQ[$];
  logic [DATA_W-1:0] wrDataQ[$];
  int                rdDueQ[$];
  int wrCmds, wrBeats, rdCmds, beatIdx, enCycles, dupCount, modelCyc, dueTmp;
  logic [ADDR_W-1:0] firstWrAddr, lastWrAddr, mAddr;
  logic [DATA_W-1:0] mData;

  // MIG model acts on the falling edge: picks ready levels, then logs what the next rising edge accepts.
  always @(negedge ui_clk) begin
    if (clearReq) begin
      mem.delete(); wrAddrQ.delete(); wrDataQ.delete(); rdAddrQ.delete(); rdDueQ.delete();
      wrCmds = 0; wrBeats = 0; rdCmds = 0; beatIdx = 0; enCycles = 0; dupCount = 0; modelCyc = 0;
      firstWrAddr = '0; lastWrAddr = '0;
      mig.app_rdy = 1'b1; mig.app_wdf_rdy = 1'b1;
      mig.app_rd_data_valid = 1'b0; mig.app_rd_data = '0;
    end else begin
      modelCyc++;
      mig.app_rd_data_valid = 1'b0;
      mig.app_rd_data = '0;
      if (rdAddrQ.size() != 0 && rdDueQ[0] <= modelCyc) begin
        mAddr  = rdAddrQ.pop_front();
        dueTmp = rdDueQ.pop_front();
        if (!(dropLast && beatIdx == dropIdx)) begin
          mData = mem.exists(mAddr) ? mem[mAddr] : '0;
          if (beatIdx == corruptIdx) mData[corruptBit] = ~mData[corruptBit];
          mig.app_rd_data_valid = 1'b1;
          mig.app_rd_data = mData;
        end
        beatIdx++;
      end
      mig.app_rdy     = stallEn ? ($urandom_range(0, 2) != 0) : 1'b1;
      mig.app_wdf_rdy = stallEn ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (mig.app_en || mig.app_wdf_wren) enCycles++;
      if (mig.app_en && mig.app_rdy) begin
        if (mig.app_cmd == 3'b000) begin
          if (wrCmds == 0) firstWrAddr = mig.app_addr;
          lastWrAddr = mig.app_addr;
          wrAddrQ.push_back(mig.app_addr);
          wrCmds++;
        end else begin
          rdAddrQ.push_back(mig.app_addr);
          rdDueQ.push_back(modelCyc + 3);
          rdCmds++;
        end
      end
      if (mig.app_wdf_wren && mig.app_wdf_rdy) begin
        wrDataQ.push_back(mig.app_wdf_data);
        wrBeats++;
      end
      while (wrAddrQ.size() != 0 && wrDataQ.size() != 0) begin
        mAddr = wrAddrQ.pop_front();
        mData = wrDataQ.pop_front();
        if (mem.exists(mAddr)) dupCount++;
        mem[mAddr] = mData;
      end
    end
  end

  function automatic logic [DATA_W-1:0] tbPattern(input int i, input logic [1:0] md, input logic [31:0] sd);
    logic [DATA_W-1:0] w = '0;
    for (int k = 0; k < DATA_W / 32; k++) begin
      if (md == 2'd0)      w[32*k +: 32] = 32'(i);
      else if (md == 2'd1) w[32*k +: 32] = 32'h1 << ((i + k) % 32);
      else if (md == 2'd2) w[32*k +: 32] = (32'(i) * 32'h9E3779B1) ^ sd ^ 32'(k);
      else                 w[32*k +: 32] = ~32'(i);
    end
    return w;
  endfunction

  function automatic int countBadWords(input logic [ADDR_W-1:0] base, input int n,
                                       input logic [1:0] md, input logic [31:0] sd);
    logic [ADDR_W-1:0] a;
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      a = base + ADDR_W'(i * 8);
      if (!mem.exists(a) || mem[a] !== tbPattern(i, md, sd)) bad++;
    end
    return bad;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] md, input logic [31:0] sd, input logic [ADDR_W-1:0] base,
                               input logic [CNT_W-1:0] n, input logic lp);
    clearReq = 1'b1;
    @(posedge ui_clk); #2;
    clearReq = 1'b0;
    mode = md; seed = sd; baseAddr = base; wordCount = n; loopEn = lp;
    start = 1'b1;
    @(posedge ui_clk); #2;
    start = 1'b0;
  endtask

  task automatic waitDone(input int maxCycles, output int cycles);
    cycles = 0;
    while (!done && cycles < maxCycles) begin
      @(posedge ui_clk); #2;
      cycles++;
    end
    if (!done) checkOutput("doneWithinBound", 64'(done), 64'd1);
  endtask

  int  cyc;
  logic stopSent;

  initial begin
    repeat (3) @(posedge ui_clk);
    #2;
    checkOutput("rstBusy", 64'(busy), 64'd0);
    checkOutput("rstAppEn", 64'({mig.app_en, mig.app_wdf_wren, mig.app_cmd}), 64'd0);
    checkOutput("rstDonePass", 64'({done, passOut}), 64'd0);
    reset = 1'b0;

    // Ideal MIG, addr-as-data
    applyStimulus(2'd0, 32'd0, 30'h1000, 16'd32, 1'b0);
    waitDone(2000, cyc);
    checkOutput("t1Pass", 64'({done, passOut}), 64'b11);
    checkOutput("t1ErrCount", 64'(errCount), 64'd0);
    checkOutput("t1PassCount", 64'(passCount), 64'd1);
    checkOutput("t1Traffic", 64'({16'(wrCmds), 16'(wrBeats), 16'(rdCmds)}), {16'd0, 16'd32, 16'd32, 16'd32});
    checkOutput("t1FirstAddr", 64'(firstWrAddr), 64'h1000);
    checkOutput("t1LastAddr", 64'(lastWrAddr), 64'h10F8);
    checkOutput("t1MemBad", 64'(countBadWords(30'h1000, 32, 2'd0, 32'd0)), 64'd0);

    // Random stalls on both write channels, walking-ones, address wraps past 2^30
    stallEn = 1'b1;
    applyStimulus(2'd1, 32'd0, 30'h3FFF_FF80, 16'd32, 1'b0);
    waitDone(3000, cyc);
    stallEn = 1'b0;
    checkOutput("t2Pass", 64'({done, passOut}), 64'b11);
    checkOutput("t2Cmds", 64'(wrCmds), 64'd32);
    checkOutput("t2Beats", 64'(wrBeats), 64'd32);
    checkOutput("t2Dups", 64'(dupCount), 64'd0);
    checkOutput("t2Unique", 64'(mem.num()), 64'd32);
    checkOutput("t2MemBad", 64'(countBadWords(30'h3FFF_FF80, 32, 2'd1, 32'd0)), 64'd0);

    // Bit 70 of word 5 flipped on readback
    corruptIdx = 5; corruptBit = 70;
    applyStimulus(2'd2, 32'hA5A5_A5A5, 30'h4000, 16'd32, 1'b0);
    waitDone(2000, cyc);
    corruptIdx = -1;
    checkOutput("t3ErrCount", 64'(errCount), 64'd1);
    checkOutput("t3ErrLanes", 64'(errLanes), 64'h02);
    checkOutput("t3FirstErrAddr", 64'(firstErrAddr), 64'h4028);
    checkOutput("t3DonePass", 64'({done, passOut}), 64'b10);

    // Last read beat dropped -> drain timeout
    dropLast = 1'b1; dropIdx = 31;
    applyStimulus(2'd3, 32'd0, 30'h0, 16'd32, 1'b0);
    waitDone(8000, cyc);
    dropLast = 1'b0;
    checkOutput("t4Timeout", 64'(timedOut), 64'd1);
    checkOutput("t4DonePass", 64'({done, passOut}), 64'b10);
    checkOutput("t4WaitedDrain", 64'(cyc >= 4096), 64'd1);

    // Looping, stop pulsed during the third pass
    applyStimulus(2'd0, 32'd0, 30'h100, 16'd4, 1'b1);
    cyc = 0; stopSent = 1'b0;
    while (!done && cyc < 5000) begin
      @(posedge ui_clk); #2;
      cyc++;
      stop = 1'b0;
      if (!stopSent && passCount == 16'd2) begin
        stop = 1'b1;
        stopSent = 1'b1;
      end
    end
    stop = 1'b0; loopEn = 1'b0;
    checkOutput("t5Done", 64'(done), 64'd1);
    checkOutput("t5PassCount", 64'(passCount), 64'd3);
    checkOutput("t5Reads", 64'(rdCmds), 64'd12);
    checkOutput("t5Pass", 64'(passOut), 64'd1);

    // Zero-length run
    applyStimulus(2'd0, 32'd0, 30'h0, 16'd0, 1'b0);
    waitDone(50, cyc);
    checkOutput("t6DonePass", 64'({done, passOut}), 64'b11);
    checkOutput("t6NoTraffic", 64'(enCycles), 64'd0);

    // Reset in the middle of the write phase, then a clean rerun
    applyStimulus(2'd0, 32'd0, 30'h800, 16'd32, 1'b0);
    cyc = 0;
    while (!mig.app_en && cyc < 50) begin
      @(posedge ui_clk); #2;
      cyc++;
    end
    checkOutput("t7WriteStarted", 64'(mig.app_en), 64'd1);
    repeat (2) @(posedge ui_clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t7RstEnWren", 64'({mig.app_en, mig.app_wdf_wren}), 64'd0);
    checkOutput("t7RstBusy", 64'(busy), 64'd0);
    @(posedge ui_clk); #2;
    reset = 1'b0;
    applyStimulus(2'd0, 32'd0, 30'h800, 16'd32, 1'b0);
    waitDone(2000, cyc);
    checkOutput("t7RerunPass", 64'({done, passOut}), 64'b11);
    checkOutput("t7RerunCmds", 64'({16'(wrCmds), 16'(rdCmds)}), {32'd0, 16'd32, 16'd32});
    checkOutput("t7RerunPassCount", 64'(passCount), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end
endmodule
